// File: rtl/uart_rcv.sv
// UART receiver: 8N1 frames (8E1 when UART_RCV_PARITY_EN is defined) with a Req/Ack
// byte handshake and one-cycle framing, overrun and parity error pulses.
`timescale 1ns/1ps
module uart_rcv #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       RxD,
    input  logic       Ack,
    output logic [7:0] char,
    output logic       Req,
    output logic       ferr,
    output logic       ovr,
    output logic       perr
);

`ifdef UART_RCV_PARITY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4, WAITHI = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4, WAITHI = 3'd5
    } state_t;
`endif

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    logic        rx_meta_q, rxs_q;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  char_q, char_d;
    logic        req_q, req_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
`ifdef UART_RCV_PARITY_EN
    logic        par_err_q, par_err_d;
    logic        perr_q, perr_d;
`endif

    // Next-state and next-output computation for the frame FSM and handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        char_d  = char_q;
        req_d   = req_q & ~Ack;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef UART_RCV_PARITY_EN
        par_err_d = par_err_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                bit_d = 3'd0;
                if (!rxs_q) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = 16'd0;
                    state_d = rxs_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 16'd0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RCV_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_RCV_PARITY_EN
            PAR: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d     = 16'd0;
                    par_err_d = rxs_q ^ even_parity(shift_q);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = 16'd0;
                    if (rxs_q) begin
                        state_d = IDLE;
                        // An Ack on this very edge frees the buffer for the new byte.
                        if (req_q && !Ack) begin
                            ovr_d = 1'b1;
                        end else begin
                            char_d = shift_q;
                            req_d  = 1'b1;
                        end
`ifdef UART_RCV_PARITY_EN
                        perr_d = par_err_q;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAITHI;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAITHI: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAITHI;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
                bit_d   = 3'd0;
            end
        endcase
    end

    // Synchronizer, FSM state and registered outputs; clr returns all to idle.
    always_ff @(posedge clk) begin
        if (clr) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            char_q    <= 8'h00;
            req_q     <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RCV_PARITY_EN
            par_err_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= RxD;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            char_q    <= char_d;
            req_q     <= req_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef UART_RCV_PARITY_EN
            par_err_q <= par_err_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign char = char_q;
    assign Req  = req_q;
    assign ferr = ferr_q;
    assign ovr  = ovr_q;
`ifdef UART_RCV_PARITY_EN
    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

endmodule
